// File: rtl/data_mem_pipe.sv
// Big-endian, byte-addressable data memory with byte/half/word accesses,
// a fixed-latency valid-tagged response pipeline and sticky fault capture.
module data_mem_pipe #(
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 16384,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              err_sticky,
    output logic [ADDR_W-1:0] err_addr,
    input  logic              err_clr
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic              accept;
    logic              fault;
    logic              out_of_range;
    logic [IDX_W-1:0]  idx0, idx1, idx2, idx3;
    logic [7:0]        b0, b1, b2, b3;
    logic [31:0]       load_data;
    logic [READ_LAT-1:0] pipe_valid;
    logic [READ_LAT-1:0] pipe_err;
    logic [31:0]       pipe_data [READ_LAT];

    assign req_ready = !reset;
    assign accept    = req_valid && !reset;

    // Any address bit at or above the index width means the access is off the end.
    assign out_of_range = (req_addr >> IDX_W) != '0;

    assign fault = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                || out_of_range;

    assign idx0 = req_addr[IDX_W-1:0];
    assign idx1 = idx0 + IDX_W'(1);
    assign idx2 = idx0 + IDX_W'(2);
    assign idx3 = idx0 + IDX_W'(3);

    assign b0 = mem[idx0];
    assign b1 = mem[idx1];
    assign b2 = mem[idx2];
    assign b3 = mem[idx3];

    always_comb begin
        load_data = '0;
        case (req_size)
            2'b00:   load_data = {{24{req_signed & b0[7]}}, b0};
            2'b01:   load_data = {{16{req_signed & b0[7]}}, b0, b1};
            2'b10:   load_data = {b0, b1, b2, b3};
            default: load_data = '0;
        endcase
    end

    // Storage is deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (accept && req_write && !fault) begin
            case (req_size)
                2'b00: mem[idx0] <= req_wdata[7:0];
                2'b01: begin
                    mem[idx0] <= req_wdata[15:8];
                    mem[idx1] <= req_wdata[7:0];
                end
                2'b10: begin
                    mem[idx0] <= req_wdata[31:24];
                    mem[idx1] <= req_wdata[23:16];
                    mem[idx2] <= req_wdata[15:8];
                    mem[idx3] <= req_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_err[i]   <= 1'b0;
                pipe_data[i]  <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && fault;
            pipe_data[0]  <= (accept && !req_write && !fault) ? load_data : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign rsp_valid = pipe_valid[READ_LAT-1];
    assign rsp_err   = pipe_err[READ_LAT-1];
    assign rsp_rdata = pipe_data[READ_LAT-1];

    // A new fault outranks a simultaneous clear so no fault address is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky <= 1'b0;
            err_addr   <= '0;
        end else if (accept && fault && (!err_sticky || err_clr)) begin
            err_sticky <= 1'b1;
            err_addr   <= req_addr;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
            err_addr   <= '0;
        end
    end

endmodule

// File: doc/data_mem_pipe.md
Name: data_mem_pipe

Overview:
Parametrised big-endian, byte-addressable data memory for the MIPS datapath. It succeeds the fixed 16 KB word-only memory and adds:
- byte, halfword and word accesses, with sign or zero extension on loads
- a valid-tagged request/response pipeline with configurable read latency
- alignment and range checking, with a sticky fault-address register

It sits between the MEM stage and the load/store unit.

Parameters:
ADDR_W, 32, request address width
DEPTH, 16384, memory size in bytes (power of two, >= 4)
READ_LAT, 1, cycles from request acceptance to response, legal range 1..4

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  request can be accepted
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  input  1  load: 1 sign-extend, 0 zero-extend; ignored on stores
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
rsp_valid  output  1  response strobe, one cycle per accepted request
rsp_rdata  output  32  load result; 0 for stores and faults
rsp_err  output  1  request faulted; qualified by rsp_valid
err_sticky  output  1  set by any faulting request
err_addr  output  ADDR_W  address of the first fault since the last clear
err_clr  input  1  clears err_sticky and err_addr

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - While reset = 1, on each edge: all pipeline valid bits, rsp_valid, rsp_rdata, rsp_err, err_sticky and err_addr go to 0.
  - Memory contents are not reset.
- Acceptance:
  - req_ready = !reset (combinational). The block accepts one request per cycle and never back-pressures.
  - A request is accepted when req_valid & req_ready at a rising edge.
- Address and endianness:
  - The memory index is req_addr[$clog2(DEPTH)-1:0].
  - Big endian: byte at address a is the most significant byte.
  - Half = {m[a], m[a+1]}; word = {m[a], m[a+1], m[a+2], m[a+3]}.
- Fault checks (evaluated at acceptance; a request is a fault if any holds):
  - req_size = 11
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - req_addr >= DEPTH
- Stores:
  - A non-faulting store updates memory at the accepting edge: byte writes only m[a] from wdata[7:0]; half writes m[a], m[a+1] from wdata[15:0]; word writes all 4 bytes.
  - A faulting store writes nothing.
- Loads:
  - Data is snapshotted at the accepting edge into pipeline stage 1.
  - A store accepted on a later cycle does not alter an in-flight load's data.
  - A load accepted the cycle after a store to the same bytes returns the new data.
  - Byte/half results are placed in the low bits and extended per req_signed to 32 bits.
- Response pipeline:
  - A READ_LAT-deep shift of {valid, err, data}.
  - A request accepted at edge N produces rsp_valid = 1 during the cycle after edge N+READ_LAT-1. With READ_LAT = 1, the response appears the cycle after acceptance.
  - Stores also produce a response (rdata = 0).
  - Faults give rsp_err = 1 and rdata = 0.
  - Back-to-back requests produce back-to-back responses in order.
- Sticky error:
  - On a faulting acceptance with err_sticky = 0: err_sticky <= 1 and err_addr <= req_addr.
  - Later faults do not overwrite err_addr.
  - err_clr = 1 clears both. If err_clr and a fault occur in the same cycle, the fault wins: sticky set, err_addr = the new address.
- Reset mid-operation: all in-flight responses are discarded and no rsp_valid is emitted for them. A request presented during reset is not accepted.

Test Plan:
- Word store/load: sw 0x11223344 @0x10, then lw @0x10 -> rsp_rdata = 0x11223344; lbu @0x10 = 0x00000011; lbu @0x13 = 0x00000044.
- Extension: sh 0x0000_8001 @0x20; lh @0x20 -> 0xFFFF8001; lhu @0x20 -> 0x00008001; sb 0x80 @0x24; lb @0x24 -> 0xFFFFFF80.
- Faults: lw @0x22 -> rsp_err = 1, rdata = 0, err_sticky = 1, err_addr = 0x22. Then sh @0x31 -> err_addr stays 0x22. sw @DEPTH -> rsp_err = 1 and memory is unchanged. err_clr -> sticky = 0.
- Latency and pipelining, for READ_LAT = 1 and 3: 4 back-to-back loads -> 4 consecutive rsp_valid pulses starting exactly READ_LAT cycles after the first acceptance, data in order.
- Hazard at READ_LAT = 3: lw @0x40 (old 0xAAAAAAAA), then sw 0x55555555 @0x40 next cycle -> load returns 0xAAAAAAAA; a following lw returns 0x55555555.
- Reset mid-flight (READ_LAT = 3): accept 2 loads, assert reset 1 cycle -> no rsp_valid; outputs 0; memory retains prior stores.
